seg7_frame_decoder: RTL and testbench

//   Receive-side monitor for the 7-segment animation output: samples a 7-bit segment bus and

---
 rtl/seg7_frame_decoder.sv | 148 ++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
// Purpose: readback monitor for a 7-segment bus; qualifies stable patterns into frames,
//          decodes them to hex digits and measures the cycle gap between frames.
// Latency: a held input change gives frame_valid on rising edge STABLE_CYCLES+3; no backpressure (monitor only).
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   segments       segment bus, active-high, bit0=a .. bit6=g (asynchronous to clk)
//   frame_valid    one-cycle pulse when a new pattern is accepted
//   frame_pattern  last accepted pattern
//   digit          hex value of frame_pattern, 0 when it is not a hex glyph
//   digit_valid    frame_pattern is a hex glyph
//   blank          frame_pattern is all segments off
//   period         cycles between the last two accepts (saturating)
//   period_valid   period holds a real measurement (two or more frames since reset)
//   frame_count    accepted-frame counter, wraps at 16 bits
module seg7_frame_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       segments,
    output logic             frame_valid,
    output logic [6:0]       frame_pattern,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [15:0]      frame_count
);

    localparam int                STAB_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PCNT_MAX = '1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_FIRST,
        S_RUN
    } state_t;

    state_t            state;
    logic [6:0]        seg_m;
    logic [6:0]        seg_s;
    logic [6:0]        cand;
    logic [STAB_W-1:0] stab_cnt;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  pcnt_inc;
    logic              accept;
    logic [4:0]        dec;

    // Returns {glyph_valid, hex_value}.
    function automatic logic [4:0] hex_decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        pcnt_inc = (pcnt == PCNT_MAX) ? PCNT_MAX : pcnt + CNT_W'(1);
    end

    // Re-accepting the pattern already on display is suppressed, so a held pattern
    // fires once and a short excursion that returns to it is invisible.
    assign accept = (stab_cnt == STAB_MAX) && (seg_s == cand) &&
                    ((state == S_WAIT) || (cand != frame_pattern));
    assign dec    = hex_decode(cand);

    // Two-flop synchronizer plus stability qualifier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_m    <= '0;
            seg_s    <= '0;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            seg_m <= segments;
            seg_s <= seg_m;
            if (seg_s != cand) begin
                cand     <= seg_s;
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + STAB_W'(1);
            end
        end
    end

    // Frame FSM with registered outputs. pcnt restarts at 0 on an accept so that
    // pcnt+1 at the next accept equals the number of cycles between them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_WAIT;
            frame_valid   <= 1'b0;
            frame_pattern <= '0;
            digit         <= '0;
            digit_valid   <= 1'b0;
            blank         <= 1'b0;
            period        <= '0;
            period_valid  <= 1'b0;
            frame_count   <= '0;
            pcnt          <= '0;
        end else begin
            frame_valid <= accept;
            pcnt        <= accept ? '0 : pcnt_inc;
            if (accept) begin
                frame_pattern <= cand;
                digit         <= dec[3:0];
                digit_valid   <= dec[4];
                blank         <= (cand == 7'h00);
                frame_count   <= frame_count + 16'd1;
                case (state)
                    S_WAIT: begin
                        state <= S_FIRST;
                    end
                    S_FIRST: begin
                        state        <= S_RUN;
                        period       <= pcnt_inc;
                        period_valid <= 1'b1;
                    end
                    S_RUN: begin
                        period <= pcnt_inc;
                    end
                    default: begin
                        state <= S_WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
module tb_seg7_frame_decoder;

    localparam int STAB  = 16;
    localparam int CW    = 8;
    localparam int PMAX  = (1 << CW) - 1;

    localparam logic [6:0] HEX_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    segments;
    logic          frame_valid;
    logic [6:0]    frame_pattern;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          blank;
    logic [CW-1:0] period;
    logic          period_valid;
    logic [15:0]   frame_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected outputs plus a description of the input history.
    logic       m_fv, m_dv, m_blank, m_pv;
    logic [6:0] m_pat;
    logic [3:0] m_dig;
    int         m_period, m_cnt;
    int         nframes, last_edge, edge_no;
    logic [6:0] m_s1, m_ss, run_val;
    int         run_len;

    seg7_frame_decoder #(.STABLE_CYCLES(STAB), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .segments      (segments),
        .frame_valid   (frame_valid),
        .frame_pattern (frame_pattern),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .blank         (blank),
        .period        (period),
        .period_valid  (period_valid),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fv = 0; m_dv = 0; m_blank = 0; m_pv = 0;
        m_pat = 0; m_dig = 0; m_period = 0; m_cnt = 0;
        nframes = 0; last_edge = 0;
        m_s1 = 0; m_ss = 0;
        // The cleared candidate counts as one sample of pattern 0.
        run_val = 0; run_len = 1;
    endtask

    task automatic check_all();
        chk("frame_valid",   32'(frame_valid),   32'(m_fv));
        chk("frame_pattern", 32'(frame_pattern), 32'(m_pat));
        chk("digit",         32'(digit),         32'(m_dig));
        chk("digit_valid",   32'(digit_valid),   32'(m_dv));
        chk("blank",         32'(blank),         32'(m_blank));
        chk("period",        32'(period),        32'(m_period));
        chk("period_valid",  32'(period_valid),  32'(m_pv));
        chk("frame_count",   32'(frame_count),   32'(m_cnt & 16'hFFFF));
    endtask

    // One clock edge: advance the model using the input seen at the edge, then compare.
    task automatic step();
        logic [6:0] v;
        @(posedge clk);
        edge_no++;
        if (reset) begin
            model_reset();
        end else begin
            v    = m_ss;          // synchronized sample seen by the qualifier at this edge
            m_ss = m_s1;
            m_s1 = segments;
            if (v == run_val) run_len++;
            else begin
                run_val = v;
                run_len = 1;
            end
            m_fv = 0;
            // STAB+1 identical synchronized samples qualify a pattern.
            if (run_len >= STAB + 1 && (nframes == 0 || v != m_pat)) begin
                m_fv = 1;
                if (nframes >= 1)
                    m_period = (edge_no - last_edge > PMAX) ? PMAX : edge_no - last_edge;
                last_edge = edge_no;
                nframes++;
                m_pat   = v;
                m_blank = (v == 7'h00);
                m_dv    = 0;
                m_dig   = 0;
                for (int i = 0; i < 16; i++) begin
                    if (HEX_TAB[i] == v) begin
                        m_dv  = 1;
                        m_dig = 4'(i);
                    end
                end
                m_cnt++;
                m_pv = (nframes >= 2);
            end
        end
        #1 check_all();
    endtask

    // Steps until frame_valid is seen; n = number of edges taken, -1 if the budget expires.
    task automatic wait_frame(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (frame_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic hold(input logic [6:0] p, input int cycles, output int pulses);
        segments = p;
        pulses   = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (frame_valid === 1'b1) pulses++;
        end
    endtask

    task automatic assert_reset_now();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_frame_valid",  32'(frame_valid),   0);
        chk("rst_pattern",      32'(frame_pattern), 0);
        chk("rst_digit_valid",  32'(digit_valid),   0);
        chk("rst_period",       32'(period),        0);
        chk("rst_period_valid", 32'(period_valid),  0);
        chk("rst_frame_count",  32'(frame_count),   0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n, pulses;
        logic [6:0] p;
        int len;

        edge_no  = 0;
        reset    = 1'b1;
        segments = 7'h00;
        model_reset();
        for (int i = 0; i < 3; i++) step();

        // Release with 06 held: one frame on edge 19.
        segments = 7'h06;
        reset    = 1'b0;
        n = -1; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (frame_valid === 1'b1) begin
                pulses++;
                if (n < 0) n = i;
            end
        end
        chk("t2_latency", n, 19);
        chk("t2_pulses", pulses, 1);
        chk("t2_digit", 32'(digit), 1);
        chk("t2_count", 32'(frame_count), 1);
        chk("t2_pvalid", 32'(period_valid), 0);

        // Short glitch returning to the accepted pattern.
        hold(7'h7F, 10, pulses);
        chk("t3_glitch_pulses_a", pulses, 0);
        hold(7'h06, 40, pulses);
        chk("t3_glitch_pulses_b", pulses, 0);
        chk("t3_pattern", 32'(frame_pattern), 32'h06);

        // Two frames exactly 100 cycles apart.
        segments = 7'h5B;
        wait_frame(40, n);
        chk("t4_first_5b", n, 19);
        for (int i = 0; i < 81; i++) step();
        segments = 7'h4F;
        wait_frame(40, n);
        chk("t4_gap", 81 + n, 100);
        chk("t4_period", 32'(period), 100);
        chk("t4_pvalid", 32'(period_valid), 1);
        chk("t4_digit", 32'(digit), 3);

        // Non-glyph and blank patterns.
        hold(7'h40, 30, pulses);
        chk("t5_40_pulses", pulses, 1);
        chk("t5_40_dvalid", 32'(digit_valid), 0);
        chk("t5_40_digit", 32'(digit), 0);
        hold(7'h00, 30, pulses);
        chk("t5_00_pulses", pulses, 1);
        chk("t5_00_blank", 32'(blank), 1);

        // Gap beyond the counter range saturates.
        segments = 7'h06;
        wait_frame(40, n);
        chk("t6_06_frame", n, 19);
        for (int i = 0; i < 300; i++) step();
        segments = 7'h5B;
        wait_frame(40, n);
        chk("t6_5b_frame", n, 19);
        chk("t6_period_sat", 32'(period), PMAX);

        // Reset with a pattern held, then full re-qualification.
        hold(7'h5B, 20, pulses);
        assert_reset_now();
        wait_frame(40, n);
        chk("t1_requal_held", n, 19);
        chk("t1_count", 32'(frame_count), 1);

        // Reset in the middle of qualifying a new pattern.
        segments = 7'h4F;
        for (int i = 0; i < 10; i++) step();
        assert_reset_now();
        wait_frame(40, n);
        chk("t1_requal_mid", n, 19);
        chk("t1_mid_pattern", 32'(frame_pattern), 32'h4F);

        // Randomized pattern sequence against the model.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) p = 7'($urandom_range(0, 127));
            else p = HEX_TAB[$urandom_range(0, 15)];
            if ($urandom_range(0, 14) == 0) len = int'($urandom_range(200, 320));
            else len = int'($urandom_range(1, 40));
            hold(p, len, pulses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
